// File: rtl/result_writer.sv
// Drains PE result pairs through a 4-entry FIFO into output memory, one word per handshake.
// Optional: define RESULT_WRITER_RELU_EN to clamp negative results to zero on the write path.
module result_writer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic [15:0] i_result_1,
  input  logic [15:0] i_result_2,
  input  logic [2:0]  i_col_idx_1,
  input  logic [2:0]  i_col_idx_2,
  input  logic [6:0]  i_row_idx,
  input  logic        i_done,
  output logic        o_wr_valid,
  output logic [9:0]  o_wr_addr,
  output logic [15:0] o_wr_data,
  input  logic        i_wr_ready,
  output logic        o_full,
  output logic        o_overflow,
  output logic        o_done,
  output logic [9:0]  o_wr_count
);

  typedef struct packed {
    logic [15:0] res1;
    logic [15:0] res2;
    logic [2:0]  col1;
    logic [2:0]  col2;
    logic [6:0]  row;
  } pair_t;

  typedef enum logic [1:0] {StIdle, StWr1, StWr2} state_e;

  pair_t       mem [4];
  pair_t       in_pair, head, next_head;
  logic [1:0]  wr_ptr_q, rd_ptr_q, rd_nxt;
  logic [2:0]  count_q, count_d;
  state_e      state_q, state_d;
  logic        valid_d;
  logic [9:0]  addr_d;
  logic [15:0] data_d;
  logic        pending_q, pending_d, fire;
  logic        hs, pop, push, full;

  function automatic logic [15:0] relu(input logic [15:0] r);
`ifdef RESULT_WRITER_RELU_EN
    return r[15] ? 16'h0000 : r;
`else
    return r;
`endif
  endfunction

  assign in_pair = '{res1: i_result_1, res2: i_result_2, col1: i_col_idx_1,
                     col2: i_col_idx_2, row: i_row_idx};
  assign full    = (count_q == 3'd4);
  assign hs      = o_wr_valid && i_wr_ready;
  assign pop     = (state_q == StWr2) && hs;
  assign push    = i_valid && (!full || pop);
  assign rd_nxt  = rd_ptr_q + 2'd1;
  assign head    = mem[rd_ptr_q];
  // With a single entry left, the pair pushed on this same edge becomes the next head.
  assign next_head = (count_q > 3'd1) ? mem[rd_nxt] : in_pair;
  assign count_d   = count_q + {2'b00, push} - {2'b00, pop};
  assign fire      = pending_q && (count_q == 3'd0) && (state_q == StIdle);
  assign pending_d = i_done || (pending_q && !fire);
  assign o_full    = full;

  always_comb begin
    state_d = state_q;
    valid_d = o_wr_valid;
    addr_d  = o_wr_addr;
    data_d  = o_wr_data;
    unique case (state_q)
      StIdle: begin
        if (count_q != 3'd0) begin
          state_d = StWr1;
          valid_d = 1'b1;
          addr_d  = {head.row, head.col1};
          data_d  = relu(head.res1);
        end
      end
      StWr1: begin
        if (hs) begin
          state_d = StWr2;
          addr_d  = {head.row, head.col2};
          data_d  = relu(head.res2);
        end
      end
      StWr2: begin
        if (hs) begin
          if ((count_q > 3'd1) || push) begin
            state_d = StWr1;
            addr_d  = {next_head.row, next_head.col1};
            data_d  = relu(next_head.res1);
          end else begin
            state_d = StIdle;
            valid_d = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_pair;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= StIdle;
      pending_q  <= 1'b0;
      o_wr_valid <= 1'b0;
      o_wr_addr  <= '0;
      o_wr_data  <= '0;
      o_overflow <= 1'b0;
      o_done     <= 1'b0;
      o_wr_count <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_nxt;
      count_q    <= count_d;
      state_q    <= state_d;
      pending_q  <= pending_d;
      o_wr_valid <= valid_d;
      o_wr_addr  <= addr_d;
      o_wr_data  <= data_d;
      o_overflow <= o_overflow || (i_valid && full && !pop);
      o_done     <= fire;
      if (hs) o_wr_count <= o_wr_count + 10'd1;
    end
  end

endmodule

// File: tb/tb_result_writer.sv
// Directed bench for result_writer; a write scoreboard checks every memory handshake in order.
`timescale 1ns/1ps
module tb_result_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_done, i_wr_ready;
  logic [15:0] i_result_1, i_result_2;
  logic [2:0]  i_col_idx_1, i_col_idx_2;
  logic [6:0]  i_row_idx;
  logic        o_wr_valid, o_full, o_overflow, o_done;
  logic [9:0]  o_wr_addr, o_wr_count;
  logic [15:0] o_wr_data;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  logic [25:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [9:0]  prev_addr;
  logic [15:0] prev_data;

  always #5 clk = ~clk;

  result_writer dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_result_1(i_result_1),
    .i_result_2(i_result_2), .i_col_idx_1(i_col_idx_1), .i_col_idx_2(i_col_idx_2),
    .i_row_idx(i_row_idx), .i_done(i_done), .o_wr_valid(o_wr_valid), .o_wr_addr(o_wr_addr),
    .o_wr_data(o_wr_data), .i_wr_ready(i_wr_ready), .o_full(o_full), .o_overflow(o_overflow),
    .o_done(o_done), .o_wr_count(o_wr_count)
  );

  function automatic logic [15:0] exp_data(input logic [15:0] r);
`ifdef RESULT_WRITER_RELU_EN
    return r[15] ? 16'h0000 : r;
`else
    return r;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard and stall-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (o_done) done_cnt <= done_cnt + 1;
      if (prev_stall) begin
        check("stall_addr", {22'b0, o_wr_addr}, {22'b0, prev_addr});
        check("stall_data", {16'b0, o_wr_data}, {16'b0, prev_data});
      end
      if (o_wr_valid && i_wr_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {22'b0, o_wr_addr}, 32'hffff_ffff);
        end else begin
          logic [25:0] e;
          e = exp_q.pop_front();
          check("wr_addr", {22'b0, o_wr_addr}, {22'b0, e[25:16]});
          check("wr_data", {16'b0, o_wr_data}, {16'b0, e[15:0]});
        end
      end
      prev_stall <= o_wr_valid && !i_wr_ready;
      prev_addr  <= o_wr_addr;
      prev_data  <= o_wr_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pair(input logic [15:0] r1, input logic [15:0] r2, input logic [2:0] c1,
                           input logic [2:0] c2, input logic [6:0] row, input logic done,
                           input logic written);
    i_valid = 1'b1; i_result_1 = r1; i_result_2 = r2;
    i_col_idx_1 = c1; i_col_idx_2 = c2; i_row_idx = row; i_done = done;
    if (written) begin
      exp_q.push_back({row, c1, exp_data(r1)});
      exp_q.push_back({row, c2, exp_data(r2)});
    end
    step();
    i_valid = 1'b0;
    i_done  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (exp_q.size() == 0 && !o_wr_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, {31'b0, ok}, 32'd1);
  endtask

  initial begin
    int d0;
    rst = 1'b1; i_valid = 0; i_done = 0; i_wr_ready = 0;
    i_result_1 = 0; i_result_2 = 0; i_col_idx_1 = 0; i_col_idx_2 = 0; i_row_idx = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'b0, o_wr_valid}, 0);
    check("rst_addr", {22'b0, o_wr_addr}, 0);
    check("rst_data", {16'b0, o_wr_data}, 0);
    check("rst_flags", {28'b0, o_full, o_overflow, o_done, 1'b0}, 0);
    check("rst_count", {22'b0, o_wr_count}, 0);
    rst = 1'b0;
    step();

    // Single pair, ready high; first write visible one edge after the push.
    i_wr_ready = 1'b1;
    push_pair(16'd5, -16'sd3, 3'd2, 3'd3, 7'd7, 1'b0, 1'b1);
    check("lat_before", {31'b0, o_wr_valid}, 0);
    step();
    check("lat_valid", {31'b0, o_wr_valid}, 1);
    check("lat_addr", {22'b0, o_wr_addr}, 58);
    check("lat_data", {16'b0, o_wr_data}, 5);
    wait_idle("idle_single");
    check("count_single", {22'b0, o_wr_count}, 2);

    // Backpressure during WR1 for five cycles.
    i_wr_ready = 1'b0;
    push_pair(16'd100, 16'd200, 3'd0, 3'd7, 7'd99, 1'b0, 1'b1);
    step();
    repeat (5) step();
    check("bp_valid", {31'b0, o_wr_valid}, 1);
    check("bp_addr", {22'b0, o_wr_addr}, 792);
    check("bp_data", {16'b0, o_wr_data}, 100);
    i_wr_ready = 1'b1;
    wait_idle("idle_bp");
    check("count_bp", {22'b0, o_wr_count}, 4);

    // Three back-to-back pairs, done with the last: six writes then one done pulse.
    push_pair(16'd1, 16'd2, 3'd0, 3'd1, 7'd0, 1'b0, 1'b1);
    push_pair(16'd3, 16'hfff0, 3'd2, 3'd3, 7'd1, 1'b0, 1'b1);
    push_pair(16'd7, 16'd8, 3'd4, 3'd5, 7'd2, 1'b1, 1'b1);
    d0 = done_cnt;
    repeat (5) step();
    check("tp_count", {22'b0, o_wr_count}, 10);
    check("tp_idle", {31'b0, o_wr_valid}, 0);
    check("done_early", {31'b0, o_done}, 0);
    step();
    check("done_pulse", {31'b0, o_done}, 1);
    step();
    check("done_clear", {31'b0, o_done}, 0);
    check("done_total", done_cnt - d0, 1);

    // Full FIFO accepts a push on the WR2 handshake edge.
    i_wr_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      push_pair(16'(10 + i), 16'(20 + i), 3'(i), 3'(i + 4), 7'(10 + i), 1'b0, 1'b1);
    check("full_4", {31'b0, o_full}, 1);
    i_wr_ready = 1'b1;
    step();
    push_pair(16'h1234, 16'h0042, 3'd6, 3'd7, 7'd50, 1'b0, 1'b1);
    check("full_pop_ovf", {31'b0, o_overflow}, 0);
    check("full_pop_full", {31'b0, o_full}, 1);
    wait_idle("idle_fullpop");
    check("count_fullpop", {22'b0, o_wr_count}, 20);
    check("ovf_still0", {31'b0, o_overflow}, 0);

    // Overflow: fifth push dropped, never written.
    i_wr_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      push_pair(16'(30 + i), 16'h8000 + 16'(i), 3'(i), 3'(7 - i), 7'(60 + i), 1'b0, 1'b1);
    check("ovf_full", {31'b0, o_full}, 1);
    check("ovf_pre", {31'b0, o_overflow}, 0);
    push_pair(16'hdead, 16'hbeef, 3'd1, 3'd1, 7'd90, 1'b0, 1'b0);
    check("ovf_set", {31'b0, o_overflow}, 1);
    i_wr_ready = 1'b1;
    wait_idle("idle_ovf");
    check("count_ovf", {22'b0, o_wr_count}, 28);
    check("ovf_sticky", {31'b0, o_overflow}, 1);

    // Reset while in WR2 discards the write and the pending done.
    i_wr_ready = 1'b0;
    push_pair(16'd11, 16'd22, 3'd1, 3'd2, 7'd3, 1'b1, 1'b1);
    step();
    i_wr_ready = 1'b1;
    step();
    i_wr_ready = 1'b0;
    check("pre_rst_count", {22'b0, o_wr_count}, 29);
    d0 = done_cnt;
    #2 rst = 1'b1;
    #1;
    check("rst_mid_valid", {31'b0, o_wr_valid}, 0);
    check("rst_mid_count", {22'b0, o_wr_count}, 0);
    exp_q.delete();
    step();
    rst = 1'b0;
    i_wr_ready = 1'b1;
    repeat (10) step();
    check("post_rst_valid", {31'b0, o_wr_valid}, 0);
    check("post_rst_count", {22'b0, o_wr_count}, 0);
    check("post_rst_done", done_cnt - d0, 0);
    check("post_rst_ovf", {31'b0, o_overflow}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/result_writer.md
RESULT_WRITER -- requirements
Module: result_writer

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have port i_valid  in  1  PE result pair present this cycle.
REQ-004 SHALL have port i_result_1  in  16  PE1 result, signed two's complement.
REQ-005 SHALL have port i_result_2  in  16  PE2 result, signed two's complement.
REQ-006 SHALL have port i_col_idx_1  in  3  output column of PE1 result.
REQ-007 SHALL have port i_col_idx_2  in  3  output column of PE2 result.
REQ-008 SHALL have port i_row_idx  in  7  output row shared by both results (0..99).
REQ-009 SHALL have port i_done  in  1  one-cycle pulse: the last pair of the pass has been presented.
REQ-010 SHALL have port o_wr_valid  out  1  output-memory write request.
REQ-011 SHALL have port o_wr_addr  out  10  write address = {row[6:0], col[2:0]}.
REQ-012 SHALL have port o_wr_data  out  16  write data.
REQ-013 SHALL have port i_wr_ready  in  1  memory accepts the write this cycle.
REQ-014 SHALL have port o_full  out  1  FIFO holds 4 entries.
REQ-015 SHALL have port o_overflow  out  1  sticky: a pair was dropped.
REQ-016 SHALL have port o_done  out  1  one-cycle pulse: pass fully written.
REQ-017 SHALL have port o_wr_count  out  10  number of completed writes since reset, wrapping.

Function
REQ-018 SHALL buffer pairs {result_1, result_2, col_1, col_2, row} in a 4-entry FIFO; a push occurs when i_valid=1 at a rising edge.
REQ-019 SHALL drop a push when the FIFO is full and no pop occurs on the same edge, and SHALL set o_overflow; the FIFO contents SHALL be unchanged.
REQ-020 SHALL accept a push into a full FIFO when a pop occurs on the same edge.
REQ-021 SHALL run a three-state FSM: IDLE -> WR1 when the FIFO is non-empty; WR1 -> WR2 on a WR1 handshake; WR2 -> WR1 on a WR2 handshake if the FIFO is still non-empty after the pop, otherwise WR2 -> IDLE.
REQ-022 SHALL write the result_1 word at {row, col_1} in WR1 and the result_2 word at {row, col_2} in WR2; the entry SHALL pop on the WR2 handshake.
REQ-023 SHALL register o_wr_valid, o_wr_addr and o_wr_data; while o_wr_valid=1 and i_wr_ready=0, these outputs SHALL hold stable.
REQ-024 SHALL complete a handshake on an edge where o_wr_valid=1 and i_wr_ready=1; o_wr_count SHALL then increment by 1, wrapping from 1023 to 0.
REQ-025 SHALL assert o_wr_valid from edge k+1 when a pair is pushed into an empty FIFO at edge k with the FSM in IDLE; with i_wr_ready tied high, back-to-back writes SHALL sustain 1 word per cycle.
REQ-026 SHALL record i_done in a pending flag; o_done SHALL pulse for exactly one cycle on the first edge where the flag is set, the FIFO is empty and the FSM is IDLE; that same edge SHALL clear the flag.
REQ-027 SHALL treat i_done and i_valid in the same cycle as the pair belonging to the pass, so o_done follows that pair's WR2 handshake.
REQ-028 SHALL drive o_full combinationally from the FIFO occupancy (occupancy = 4).

Reset
REQ-029 SHALL, while rst=1, asynchronously clear the FIFO pointers and occupancy, FSM=IDLE, pending flag=0, o_wr_valid=0, o_wr_addr=0, o_wr_data=0, o_overflow=0, o_done=0 and o_wr_count=0.
REQ-030 SHALL discard any in-flight write and all buffered pairs when rst is asserted mid-operation, without completing them.

Configuration
REQ-031 SHALL, when macro RESULT_WRITER_RELU_EN is defined, replace negative results (bit 15 = 1) with 16'h0000 at the moment the word is loaded into o_wr_data.
REQ-032 SHALL, when RESULT_WRITER_RELU_EN is undefined, pass results to o_wr_data unmodified.

Verification
REQ-033 SHALL cover single pair: i_wr_ready=1, push {res 5, -3; col 2, 3; row 7} -> writes (addr 58, 5) then (addr 59, -3, or 0 with RELU), o_wr_count=2.
REQ-034 SHALL cover backpressure: i_wr_ready=0 for 5 cycles during WR1 -> addr and data stable throughout; then ready=1 -> both words written in order.
REQ-035 SHALL cover overflow: i_wr_ready=0, 5 consecutive pushes -> o_full=1 after 4 pushes, o_overflow=1, 5th pair never written.
REQ-036 SHALL cover full with simultaneous pop: FIFO full, WR2 handshake coincides with i_valid=1 -> pair accepted, o_overflow stays 0.
REQ-037 SHALL cover done: i_done together with the last of 3 pairs -> single o_done pulse exactly one cycle after the 6th handshake.
REQ-038 SHALL cover reset mid-write: rst pulse while in WR2 -> o_wr_valid=0 immediately, o_wr_count=0, no o_done.
